// File: rtl/noc_params.sv
// noc_params: shared NoC sizing constants and types.
//   PORT_NUM / VC_NUM : router ports and VCs per input port
//   VC_SIZE / PORT_SIZE : encoded widths of a VC id and a port id
//   port_t     : encoded output port
//   vc_state_t : per-VC tracker state (IDLE, VA, ACTIVE)
package noc_params;

  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PORT_SIZE = $clog2(PORT_NUM);

  typedef logic [PORT_SIZE-1:0] port_t;

  typedef enum logic [1:0] {
    IDLE,
    VA,
    ACTIVE
  } vc_state_t;

endpackage

// File: rtl/input_vc_fsm.sv
// input_vc_fsm: state, occupancy count, route and downstream-VC registers
// for a single virtual channel of an input port.
// Optional build macro: VC_PROTOCOL_CHECK_EN adds the sticky err output.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_valid/wr_head     flit written into this VC's buffer, head marker
//   route                route-computation port, valid with a head write
//   rd_valid/rd_tail     flit popped by switch traversal, tail marker
//   vc_valid/vc_new      allocation grant and granted downstream VC
//   vc_request           allocation request (state VA)
//   out_port             latched route
//   downstream_vc        latched downstream VC
//   active               ACTIVE with buffered flits
//   idle                 IDLE with an empty buffer
//   err                  sticky protocol-violation flag (optional)
module input_vc_fsm #(
  parameter int BUFFER_SIZE = 4,
  parameter int PORT_W      = 3,
  parameter int VC_W        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic              wr_head,
  input  logic [PORT_W-1:0] route,
  input  logic              rd_valid,
  input  logic              rd_tail,
  input  logic              vc_valid,
  input  logic [VC_W-1:0]   vc_new,
  output logic              vc_request,
  output logic [PORT_W-1:0] out_port,
  output logic [VC_W-1:0]   downstream_vc,
  output logic              active,
  output logic              idle
`ifdef VC_PROTOCOL_CHECK_EN
  ,
  output logic              err
`endif
);

  import noc_params::*;

  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  vc_state_t        state;
  logic [CNT_W-1:0] count;

  logic empty;
  logic full;
  logic do_pop;
  logic wr_ok;
  logic do_wr;

  always_comb begin
    empty  = (count == '0);
    do_pop = rd_valid && !empty;
    // A pop in the same cycle frees a slot, so a write at full is only
    // dropped when nothing leaves; write+pop at full keeps count at full.
    full   = (count == CNT_FULL) && !do_pop;
    // Only a head opens a packet in IDLE; heads are illegal once a packet
    // owns the VC.
    wr_ok  = (state == IDLE) ? wr_head : !wr_head;
    do_wr  = wr_valid && wr_ok && !full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      out_port      <= '0;
      downstream_vc <= '0;
    end else begin
      if (do_wr && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (!do_wr && do_pop) begin
        count <= count - CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (do_wr) begin
            out_port <= route;
            state    <= VA;
          end
        end
        VA: begin
          if (vc_valid) begin
            downstream_vc <= vc_new;
            state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (do_pop && rd_tail) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    vc_request = (state == VA);
    active     = (state == ACTIVE) && !empty;
    idle       = (state == IDLE) && empty;
  end

`ifdef VC_PROTOCOL_CHECK_EN
  logic violation;

  always_comb begin
    violation = (wr_valid && (state == IDLE) && !wr_head)
             || (wr_valid && wr_head && (state != IDLE))
             || (wr_valid && full)
             || (rd_valid && empty)
             || (vc_valid && (state != VA));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (violation) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/input_vc_tracker.sv
// input_vc_tracker: per-input-port VC state tracker, requesting side of VC
// allocation. One input_vc_fsm per VC; this level only slices the vectors.
// Optional build macro: VC_PROTOCOL_CHECK_EN adds err_o.
// Ports (per-VC bit / field v):
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_valid_i/head/tail       buffer write and flit type
//   route_i                    VC_NUM x PORT_SIZE route, valid with heads
//   rd_valid_i/rd_tail_i       buffer pop and tail marker
//   vc_request_o               VC allocation request
//   out_port_o                 VC_NUM x PORT_SIZE latched route
//   vc_valid_i/vc_new_i        allocation grant, VC_NUM x VC_SIZE granted VC
//   downstream_vc_o            VC_NUM x VC_SIZE latched downstream VC
//   active_o                   ACTIVE with buffered flits
//   idle_o                     IDLE and empty, to upstream allocator
//   err_o                      sticky protocol-violation flags (optional)
module input_vc_tracker #(
  parameter  int VC_NUM      = 2,
  parameter  int PORT_NUM    = 5,
  parameter  int BUFFER_SIZE = 4,
  localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int PORT_SIZE   = $clog2(PORT_NUM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [VC_NUM-1:0]           wr_valid_i,
  input  logic [VC_NUM-1:0]           wr_head_i,
  input  logic [VC_NUM-1:0]           wr_tail_i,
  input  logic [VC_NUM*PORT_SIZE-1:0] route_i,
  input  logic [VC_NUM-1:0]           rd_valid_i,
  input  logic [VC_NUM-1:0]           rd_tail_i,
  output logic [VC_NUM-1:0]           vc_request_o,
  output logic [VC_NUM*PORT_SIZE-1:0] out_port_o,
  input  logic [VC_NUM-1:0]           vc_valid_i,
  input  logic [VC_NUM*VC_SIZE-1:0]   vc_new_i,
  output logic [VC_NUM*VC_SIZE-1:0]   downstream_vc_o,
  output logic [VC_NUM-1:0]           active_o,
  output logic [VC_NUM-1:0]           idle_o
`ifdef VC_PROTOCOL_CHECK_EN
  ,
  output logic [VC_NUM-1:0]           err_o
`endif
);

  import noc_params::*;

  // Packet end is taken from the pop side, so the write-side tail marker
  // carries no state; a head+tail write still walks IDLE -> VA -> ACTIVE.
  logic unused_wr_tail;
  assign unused_wr_tail = ^wr_tail_i;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    input_vc_fsm #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .PORT_W      (PORT_SIZE),
      .VC_W        (VC_SIZE)
    ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_valid      (wr_valid_i[v]),
      .wr_head       (wr_head_i[v]),
      .route         (route_i[v*PORT_SIZE +: PORT_SIZE]),
      .rd_valid      (rd_valid_i[v]),
      .rd_tail       (rd_tail_i[v]),
      .vc_valid      (vc_valid_i[v]),
      .vc_new        (vc_new_i[v*VC_SIZE +: VC_SIZE]),
      .vc_request    (vc_request_o[v]),
      .out_port      (out_port_o[v*PORT_SIZE +: PORT_SIZE]),
      .downstream_vc (downstream_vc_o[v*VC_SIZE +: VC_SIZE]),
      .active        (active_o[v]),
      .idle          (idle_o[v])
`ifdef VC_PROTOCOL_CHECK_EN
      ,
      .err           (err_o[v])
`endif
    );
  end

endmodule

// File: tb/tb_input_vc_tracker.sv
// tb_input_vc_tracker: directed bench for input_vc_tracker with default
// parameters (2 VCs, 5 ports, 4-flit buffers). Inputs are driven at the
// falling edge and outputs sampled at the following falling edge.
// Build with VC_PROTOCOL_CHECK_EN to also exercise err_o.
module tb_input_vc_tracker;

  localparam int VN = 2;
  localparam int PS = 3;
  localparam int VS = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [VN-1:0]    wr_valid_i, wr_head_i, wr_tail_i;
  logic [VN*PS-1:0] route_i;
  logic [VN-1:0]    rd_valid_i, rd_tail_i;
  logic [VN-1:0]    vc_request_o;
  logic [VN*PS-1:0] out_port_o;
  logic [VN-1:0]    vc_valid_i;
  logic [VN*VS-1:0] vc_new_i;
  logic [VN*VS-1:0] downstream_vc_o;
  logic [VN-1:0]    active_o, idle_o;
`ifdef VC_PROTOCOL_CHECK_EN
  logic [VN-1:0]    err_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_vc_tracker #(
    .VC_NUM      (VN),
    .PORT_NUM    (5),
    .BUFFER_SIZE (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_valid_i      (wr_valid_i),
    .wr_head_i       (wr_head_i),
    .wr_tail_i       (wr_tail_i),
    .route_i         (route_i),
    .rd_valid_i      (rd_valid_i),
    .rd_tail_i       (rd_tail_i),
    .vc_request_o    (vc_request_o),
    .out_port_o      (out_port_o),
    .vc_valid_i      (vc_valid_i),
    .vc_new_i        (vc_new_i),
    .downstream_vc_o (downstream_vc_o),
    .active_o        (active_o),
    .idle_o          (idle_o)
`ifdef VC_PROTOCOL_CHECK_EN
    ,
    .err_o           (err_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wr_valid_i = '0;
    wr_head_i  = '0;
    wr_tail_i  = '0;
    route_i    = '0;
    rd_valid_i = '0;
    rd_tail_i  = '0;
    vc_valid_i = '0;
    vc_new_i   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    clr();
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    repeat (2) @(negedge clk);
    check_eq("rst_idle", 32'(idle_o), 32'h3);
    check_eq("rst_req", 32'(vc_request_o), 32'h0);
    check_eq("rst_active", 32'(active_o), 32'h0);
    check_eq("rst_out_port", 32'(out_port_o), 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("rel_idle", 32'(idle_o), 32'h3);

    // Asynchronous reset mid-packet on VC1
    wr_valid_i = 2'b10; wr_head_i = 2'b10; route_i = 6'b100_000;
    tick();
    check_eq("mid_pre_req", 32'(vc_request_o), 32'h2);
    check_eq("mid_pre_port", 32'(out_port_o), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(vc_request_o), 32'h0);
    check_eq("mid_rst_idle", 32'(idle_o), 32'h3);
    check_eq("mid_rst_port", 32'(out_port_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("mid_rel_idle", 32'(idle_o), 32'h3);

    // Packet through VC0: head, grant, 3 bodies, 4 pops (last is tail)
    wr_valid_i = 2'b01; wr_head_i = 2'b01; route_i = 6'd3;
    tick();
    check_eq("a_req", 32'(vc_request_o), 32'h1);
    check_eq("a_port", 32'(out_port_o[2:0]), 32'h3);
    check_eq("a_act0", 32'(active_o), 32'h0);
    check_eq("a_idle", 32'(idle_o), 32'h2);
    vc_valid_i = 2'b01; vc_new_i = 2'b01;
    tick();
    check_eq("a_grant_act", 32'(active_o), 32'h1);
    check_eq("a_grant_req", 32'(vc_request_o), 32'h0);
    check_eq("a_dvc", 32'(downstream_vc_o[0]), 32'h1);
    for (int unsigned i = 0; i < 3; i++) begin
      wr_valid_i = 2'b01;
      tick();
    end
    for (int unsigned i = 0; i < 3; i++) begin
      rd_valid_i = 2'b01;
      tick();
    end
    check_eq("a_pre_tail_act", 32'(active_o), 32'h1);
    check_eq("a_pre_tail_idle", 32'(idle_o), 32'h2);
    rd_valid_i = 2'b01; rd_tail_i = 2'b01;
    tick();
    check_eq("a_tail_idle", 32'(idle_o), 32'h3);
    check_eq("a_tail_act", 32'(active_o), 32'h0);

    // VC1 held in VA for 20 cycles while VC0 runs a single-flit packet
    wr_valid_i = 2'b10; wr_head_i = 2'b10; route_i = 6'b010_000;
    tick();
    for (int unsigned k = 1; k <= 20; k++) begin
      check_eq("va_hold_req1", 32'(vc_request_o[1]), 32'h1);
      case (k)
        1: begin
          wr_valid_i = 2'b01; wr_head_i = 2'b01; wr_tail_i = 2'b01; route_i = 6'd1;
        end
        2: begin
          check_eq("va_both_req", 32'(vc_request_o), 32'h3);
          check_eq("va_vc0_port", 32'(out_port_o[2:0]), 32'h1);
          vc_valid_i = 2'b01; vc_new_i = 2'b00;
        end
        3: begin
          check_eq("va_vc0_act", 32'(active_o[0]), 32'h1);
          check_eq("va_vc0_req", 32'(vc_request_o[0]), 32'h0);
          check_eq("va_vc0_dvc", 32'(downstream_vc_o[0]), 32'h0);
          rd_valid_i = 2'b01; rd_tail_i = 2'b01;
        end
        4: check_eq("va_vc0_idle", 32'(idle_o[0]), 32'h1);
        default: ;
      endcase
      tick();
    end
    check_eq("va_c21_req", 32'(vc_request_o[1]), 32'h1);
    vc_valid_i = 2'b10; vc_new_i = 2'b10;
    tick();
    check_eq("va_c22_req", 32'(vc_request_o[1]), 32'h0);
    check_eq("va_c22_act", 32'(active_o[1]), 32'h1);
    check_eq("va_c22_dvc", 32'(downstream_vc_o[1]), 32'h1);
    check_eq("va_c22_port", 32'(out_port_o[5:3]), 32'h2);
    rd_valid_i = 2'b10; rd_tail_i = 2'b10;
    tick();
    check_eq("va_vc1_idle", 32'(idle_o), 32'h3);

    // Buffer boundaries on VC0
    wr_valid_i = 2'b01; wr_head_i = 2'b01;
    tick();
    vc_valid_i = 2'b01;
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      wr_valid_i = 2'b01;
      tick();
    end
    wr_valid_i = 2'b01;              // 5th flit, dropped
    tick();
    wr_valid_i = 2'b01; rd_valid_i = 2'b01;
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      rd_valid_i = 2'b01;
      tick();
    end
    check_eq("bnd_cnt1_act", 32'(active_o[0]), 32'h1);
    rd_valid_i = 2'b01;
    tick();
    check_eq("bnd_cnt0_act", 32'(active_o[0]), 32'h0);
    check_eq("bnd_cnt0_idle", 32'(idle_o[0]), 32'h0);
    rd_valid_i = 2'b01;              // pop at empty, ignored
    tick();
    check_eq("bnd_empty_act", 32'(active_o[0]), 32'h0);
    wr_valid_i = 2'b01;
    tick();
    check_eq("bnd_refill_act", 32'(active_o[0]), 32'h1);
    rd_valid_i = 2'b01; rd_tail_i = 2'b01;
    tick();
    check_eq("bnd_end_idle", 32'(idle_o), 32'h3);

    // Single-flit packet on VC1
    wr_valid_i = 2'b10; wr_head_i = 2'b10; wr_tail_i = 2'b10; route_i = 6'b011_000;
    tick();
    check_eq("sf_req", 32'(vc_request_o), 32'h2);
    check_eq("sf_idle", 32'(idle_o), 32'h1);
    check_eq("sf_act", 32'(active_o), 32'h0);
    vc_valid_i = 2'b10; vc_new_i = 2'b00;
    tick();
    check_eq("sf_grant_act", 32'(active_o), 32'h2);
    check_eq("sf_grant_req", 32'(vc_request_o), 32'h0);
    check_eq("sf_dvc", 32'(downstream_vc_o[1]), 32'h0);
    rd_valid_i = 2'b10; rd_tail_i = 2'b10;
    tick();
    check_eq("sf_tail_idle", 32'(idle_o), 32'h3);
    check_eq("sf_tail_act", 32'(active_o), 32'h0);

    // Body write into IDLE VC0 is not counted and leaves it IDLE
    rst_n = 1'b0;
    #1;
`ifdef VC_PROTOCOL_CHECK_EN
    check_eq("err_rst", 32'(err_o), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid_i = 2'b01;
    tick();
    check_eq("viol_idle", 32'(idle_o), 32'h3);
    check_eq("viol_req", 32'(vc_request_o), 32'h0);
`ifdef VC_PROTOCOL_CHECK_EN
    check_eq("err_set", 32'(err_o), 32'h1);
    repeat (3) tick();
    check_eq("err_sticky", 32'(err_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("err_clear", 32'(err_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_vc_tracker.md
Name: input_vc_tracker

Overview:
- Per-input-port virtual-channel (VC) state tracker. It is the requesting side of the VC allocation interface.
- For each local VC it:
  - records the route of an arriving head flit;
  - raises a VC request toward the allocator and latches the downstream VC that is granted;
  - holds the packet in ACTIVE until its tail flit leaves the buffer.
- It also drives the per-VC idle status that the upstream router's allocator uses to free VCs.
- One instance sits in each router input port, beside the flit buffers.

Parameters:
- VC_NUM, default 2: VCs per input port.
- PORT_NUM, default 5: router ports, which are the possible out_port values.
- BUFFER_SIZE, default 4: flit slots per VC buffer.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid_i  in  VC_NUM  a flit is written into VC v this cycle.
- wr_head_i  in  VC_NUM  the written flit is a head.
- wr_tail_i  in  VC_NUM  the written flit is a tail. Head and tail together means a single-flit packet.
- route_i  in  VC_NUM x PORT_SIZE  route-computation output port. Valid with head writes.
- rd_valid_i  in  VC_NUM  a flit is popped from VC v by switch traversal.
- rd_tail_i  in  VC_NUM  the popped flit is a tail.
- vc_request_o  out  VC_NUM  VC allocation request.
- out_port_o  out  VC_NUM x PORT_SIZE  latched route.
- vc_valid_i  in  VC_NUM  allocation grant.
- vc_new_i  in  VC_NUM x VC_SIZE  granted downstream VC, valid with vc_valid_i.
- downstream_vc_o  out  VC_NUM x VC_SIZE  latched downstream VC.
- active_o  out  VC_NUM  VC is in ACTIVE with count > 0. Used by the switch allocator.
- idle_o  out  VC_NUM  VC is in IDLE with count == 0. Sent to the upstream allocator.

Behaviour:
- Per-VC state vc_state_t: IDLE, VA, ACTIVE. Per-VC count register has width $clog2(BUFFER_SIZE+1).
- Reset values:
  - state = IDLE, count = 0, out_port = 0, downstream_vc = 0.
  - Outputs: vc_request_o = 0, active_o = 0, idle_o = all 1.
- All outputs are combinational decodes of registers only. There is no input-to-output path.
- IDLE:
  - A head write latches route_i into out_port and moves to VA next cycle.
  - A non-head write in IDLE is a protocol violation: the flit is not counted and state stays IDLE.
- VA:
  - vc_request_o = 1.
  - On vc_valid_i, latch vc_new_i and move to ACTIVE next cycle. The request drops in that same next cycle, so there is exactly one cycle of grant overlap.
  - Without a grant, the VC stays in VA indefinitely.
- ACTIVE:
  - A pop with rd_tail_i moves to IDLE next cycle.
  - Upstream never writes a new head into a VC before that VC has reported idle. A head write in ACTIVE or VA is therefore a violation and is ignored.
- Count:
  - +1 on an accepted write, -1 on a pop; simultaneous write and pop leaves it unchanged.
  - A write when count == BUFFER_SIZE is dropped (no wrap).
  - A pop when count == 0 is ignored (no underflow).
- Single-flit packet: head+tail write gives IDLE -> VA -> ACTIVE. One pop with rd_tail returns the VC to IDLE with count 0.
- Idle latency: idle_o rises exactly 1 cycle after the tail-pop cycle.
- Asserting rst_n low mid-packet returns every VC to IDLE/empty immediately, independent of clk.

Optional Feature:
- Macro VC_PROTOCOL_CHECK_EN.
- When defined:
  - Adds output err_o (VC_NUM, sticky, reset 0).
  - The bit for VC v sets on any of: non-head write in IDLE; head write outside IDLE; write when full; pop when empty; vc_valid_i outside VA.
  - The bit clears only on reset.
- When undefined: the port and all check logic are absent. Violations are still silently ignored as described in Behaviour.

Decomposition:
- The shared noc_params package holds PORT_NUM, VC_NUM, VC_SIZE, PORT_SIZE, port_t, and a new enum vc_state_t {IDLE, VA, ACTIVE}.
- Sub-module input_vc_fsm holds one VC's state, count, out_port and downstream_vc registers. It is instantiated VC_NUM times via generate.
- The top level only slices the vectors.

Test Plan:
- Reset, then release: idle_o = 2'b11, vc_request_o = 0, active_o = 0. Pulse rst_n low mid-clock: state clears without a clock edge.
- Packet through VC0:
  - Head write on VC0 with route_i = 3 gives vc_request_o[0] = 1 next cycle and out_port_o[0] = 3.
  - Grant vc_new_i = 1 gives downstream_vc_o[0] = 1 and active_o[0] = 1.
  - Three body writes, then four pops with the last carrying tail, give idle_o[0] = 1 one cycle after the tail pop.
- Hold VC1 in VA with no grant for 20 cycles: vc_request_o[1] stays 1 and VC0 operates independently. Grant on cycle 21 leaves the request low on cycle 22.
- Buffer boundaries:
  - Fill VC0 to 4 flits, write a 5th: count stays 4.
  - Simultaneous write+pop at full: count stays 4.
  - Pop at empty: count stays 0.
- Single-flit packet (head+tail) on VC1: IDLE -> VA -> ACTIVE; one tail pop gives idle_o[1] = 1 after 1 cycle.
- With VC_PROTOCOL_CHECK_EN: body write into an IDLE VC0 gives err_o[0] = 1, which stays set until reset, while err_o[1] = 0.
